ula_md: RTL and testbench
=========================

Name: ula_md

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operations, with a start/done handshake.
- Sits beside the single-cycle ula in the execute stage. The core stalls on busy and captures data_out when done pulses.
- Adds multi-cycle sequencing, flush, and RISC-V divide-by-zero/overflow semantics.

Parameters:
- WIDTH, 32, operand/result width in bits (legal: 4..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- flush  input  1  abort the in-flight operation (pipeline kill)
- select_md  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- data1_in  input  WIDTH  rs1 (multiplicand / dividend)
- data2_in  input  WIDTH  rs2 (multiplier / divisor)
- data_out  output  WIDTH  result register; holds until the next completion
- busy  output  1  high in CALC or FIX
- done  output  1  one-cycle completion pulse
- zero  output  1  combinational, (data_out == 0)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, data_out=0, busy=0, done=0, so zero=1.
  - All internal accumulators and the counter clear.
- States: IDLE, CALC, FIX, DONE.
- Start edge E0: start=1 while in IDLE or DONE.
  - Latch the operands and select_md.
  - Record the operand signs per op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MUL, MULHU, DIVU, REMU: both unsigned. MUL's low half is sign-independent.
  - Take absolute values of the signed operands, load counter=WIDTH, go to CALC.
- Special cases resolved at E0 (go straight to DONE, done=1 in the following cycle):
  - Divisor 0:
    - DIV/DIVU: data_out = all ones.
    - REM/REMU: data_out = data1_in.
  - Signed overflow (DIV/REM with data1_in = 1 followed by zeros, data2_in = all ones):
    - DIV: data_out = data1_in.
    - REM: data_out = 0.
- CALC: one iteration per cycle; the counter decrements each cycle; on the cycle it reaches 1, go to FIX.
  - Multiply: radix-2 shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract; WIDTH-bit quotient and WIDTH+1-bit partial remainder.
- FIX (one cycle): apply sign correction, select the result, load data_out, go to DONE.
  - Product: negate the 2*WIDTH product if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the dividend's sign.
  - Result select: MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- DONE (one cycle): done=1.
  - Next state is IDLE, or a new accept if start=1 (back-to-back, no bubble).
- Latency:
  - Normal op: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+1 edges after E0.
  - Special case: done is high after E0 + 1 edge.
  - busy is high from after E0 until FIX completes.
- start while busy: ignored; no queueing.
- flush=1 in CALC/FIX:
  - Next edge returns to IDLE; busy=0; no done pulse; data_out keeps its previous value.
  - flush has priority over start on the same edge.
  - flush in IDLE/DONE has no effect except cancelling a same-edge start.
- Changing operand inputs after E0 has no effect on the result.
- Reset asserted mid-operation aborts immediately to reset values.

Test Plan:
- MUL data1=7, data2=0xFFFFFFFD (-3), WIDTH=32 -> data_out=0xFFFFFFEB.
  - done is a single pulse 33 edges after the start edge; busy high for 33 cycles; zero=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MUL 0x10000 x 0x10000 -> 0x00000000 with zero=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
- REM -7 / 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14.
- REMU 100 / 7 -> 2.
- REM 7 / 0xFFFFFFFE (-2) -> 1.
- Special cases (each with done 1 edge after start, busy never high):
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Handshake and abort:
  - Start a DIVU, pulse start again at cycle 5 with different operands -> ignored, first result returned.
  - Start MUL, assert flush at cycle 10 -> busy=0 next edge, no done, data_out unchanged.
  - Start MUL, drop rst_n at cycle 12 -> data_out=0, busy=0, done=0 asynchronously.
- Back-to-back: start held high in the DONE cycle -> second op accepted, second done exactly 33 edges later.
- Repeat with WIDTH=8: MULHU 0xFF x 0xFF -> 0xFE, latency 9 edges.

Source files
------------

// File: rtl/ula_md.sv
// ula_md: iterative RV32M multiply/divide unit for the execute stage.
//
// Handshake: start is sampled only when the unit is idle or finishing
// (IDLE or DONE). The accepting edge latches operands and funct3. busy is
// high while an operation is in flight (CALC, FIX). done is a one-cycle
// pulse in the cycle data_out first shows the new result. start while busy
// is dropped, not queued. flush aborts an in-flight operation without a done
// pulse and also cancels a same-edge start.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request
//   flush      pipeline kill of the in-flight operation
//   select_md  funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   data1_in   rs1 (multiplicand / dividend)
//   data2_in   rs2 (multiplier / divisor)
//   data_out   result register, held until the next completion
//   busy       operation in flight
//   done       one-cycle completion pulse
//   zero       data_out == 0
module ula_md #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       select_md,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  // Latched operation context
  logic [2:0]         op_q;
  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder takes the dividend's sign
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opb;       // multiplicand (mul) or divisor (div)
  // Low half holds the multiplier (mul) or the dividend shifting out while
  // quotient bits shift in (div); the full register is the 2*WIDTH product.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;

  // Decode of the request presented on the inputs
  logic             accept;
  logic             is_div_in, s1_in, s2_in, neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_val;

  // Iteration datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_result;

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;

  always_comb begin
    is_div_in = select_md[2];
    if (is_div_in) begin
      s1_in = ~select_md[0];
      s2_in = ~select_md[0];
    end else begin
      s1_in = (select_md[1:0] == 2'b01) || (select_md[1:0] == 2'b10);
      s2_in = (select_md[1:0] == 2'b01);
    end
    neg1 = s1_in & data1_in[WIDTH-1];
    neg2 = s2_in & data2_in[WIDTH-1];
    abs1 = neg1 ? (~data1_in + 1'b1) : data1_in;
    abs2 = neg2 ? (~data2_in + 1'b1) : data2_in;

    div_zero = is_div_in && (data2_in == '0);
    div_ovf  = is_div_in && !select_md[0] && (data1_in == MIN_NEG) && (data2_in == '1);
    special  = div_zero || div_ovf;

    special_val = '1;
    if (div_zero) begin
      special_val = select_md[1] ? data1_in : '1;
    end else if (div_ovf) begin
      special_val = select_md[1] ? '0 : data1_in;
    end
  end

  // One radix-2 multiply step and one restoring divide step. The divide
  // forms the WIDTH+1-bit partial remainder from rem and the next dividend
  // bit; its sign bit after the trial subtract decides restore vs keep.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : '0);
    div_shift = {rem, prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  always_comb begin
    prod_s = neg_res ? (~prod + 1'b1) : prod;
    quo_s  = neg_res ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
    rem_s  = neg_rem ? (~rem + 1'b1) : rem;
    fix_result = '0;
    case (op_q)
      3'b000:                 fix_result = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = quo_s;
      default:                fix_result = rem_s;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = special ? S_DONE : S_CALC;
        else        state_next = S_IDLE;
      end
      S_CALC: begin
        if (flush)                         state_next = S_IDLE;
        else if (cnt == CNT_W'(1))         state_next = S_FIX;
      end
      S_FIX: state_next = flush ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == S_CALC) || (state == S_FIX);
    done = (state == S_DONE);
  end

  assign zero = (data_out == '0);

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      opb      <= '0;
      prod     <= '0;
      rem      <= '0;
      data_out <= '0;
    end else if (accept) begin
      op_q    <= select_md;
      neg_res <= neg1 ^ neg2;
      neg_rem <= neg1;
      cnt     <= CNT_W'(WIDTH);
      rem     <= '0;
      if (is_div_in) begin
        prod <= {{WIDTH{1'b0}}, abs1};
        opb  <= abs2;
      end else begin
        prod <= {{WIDTH{1'b0}}, abs2};
        opb  <= abs1;
      end
      if (special) data_out <= special_val;
    end else if ((state == S_CALC) && !flush) begin
      cnt <= cnt - 1'b1;
      if (op_q[2]) begin
        rem                <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        prod[WIDTH-1:0]    <= {prod[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        prod <= {mul_sum, prod[WIDTH-1:1]};
      end
    end else if ((state == S_FIX) && !flush) begin
      data_out <= fix_result;
    end
  end

endmodule

// File: tb/tb_ula_md.sv
module tb_ula_md;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (WIDTH=32) ----------------
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] d1 = '0, d2 = '0;
  logic [31:0] dout;
  logic        busy, done, zero;

  ula_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .select_md(sel), .data1_in(d1), .data2_in(d2),
    .data_out(dout), .busy(busy), .done(done), .zero(zero)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic       s8_start = 1'b0, s8_flush = 1'b0;
  logic [2:0] s8_sel = '0;
  logic [7:0] s8_d1 = '0, s8_d2 = '0;
  logic [7:0] s8_dout;
  logic       s8_busy, s8_done, s8_zero;

  ula_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .flush(s8_flush),
    .select_md(s8_sel), .data1_in(s8_d1), .data2_in(s8_d2),
    .data_out(s8_dout), .busy(s8_busy), .done(s8_done), .zero(s8_zero)
  );

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];
  logic [31:0] last_res = '0;
  logic [31:0] mon_e;
  logic [7:0]  mon_e8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation pending, expected done=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", dout, mon_e);
        check("zero", zero, mon_e == 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s8_done) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_w8: done=1 with no operation pending, expected done=0");
      end else begin
        mon_e8 = exp8_q.pop_front();
        check("data_out_w8", s8_dout, mon_e8);
        check("zero_w8", s8_zero, mon_e8 == 8'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after the accepting edge; counts edges until done is seen and
  // the cycles busy was high on the way. poke re-raises start mid-operation.
  task automatic wait_done(input bit poke, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (poke && lat == 5) begin
        start = 1'b1;
        sel   = DIVU;
        d1    = 32'd200;
        d2    = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  // exp_lat: edges from the accepting edge to the cycle done is high
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit poke);
    int lat, busy_cnt;
    @(negedge clk);
    sel = op; d1 = a; d2 = b; start = 1'b1;
    exp_q.push_back(exp);
    last_res = exp;
    @(posedge clk); #1;
    start = 1'b0;
    // operands change after acceptance and must not matter
    sel = ~op; d1 = ~a; d2 = ~b;
    wait_done(poke, lat, busy_cnt);
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
  endtask

  initial begin
    int lat, busy_cnt, lat8;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_data_out", dout, 32'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_zero", zero, 1'b1);
    rst_n = 1'b1;

    // WIDTH=8: MULHU 0xFF x 0xFF = 0xFE01, high byte 0xFE, 9 edges
    @(negedge clk);
    s8_sel = MULHU; s8_d1 = 8'hFF; s8_d2 = 8'hFF; s8_start = 1'b1;
    exp8_q.push_back(8'hFE);
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat8 = 0;
    while (!s8_done && lat8 < 50) begin
      @(posedge clk); #1;
      lat8++;
    end
    check("latency_w8", lat8, 9);

    // multiplies: 33 edges each
    run_op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
    run_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    run_op(MUL,    32'h00010000, 32'h00010000, 32'h00000000, 33, 1'b0);
    run_op(MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33, 1'b0);

    // divides
    run_op(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run_op(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op(DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b0);
    run_op(REMU,   32'd100,      32'd7,        32'd2,        33, 1'b0);
    run_op(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);

    // special cases: done in the cycle right after the accepting edge, no busy
    run_op(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0, 1'b0);
    run_op(REMU,   32'd5,        32'd0,        32'd5,        0, 1'b0);
    run_op(REM,    32'd7,        32'd0,        32'd7,        0, 1'b0);
    run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);
    run_op(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1'b0);

    // start while busy is ignored
    run_op(DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b1);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    sel = MUL; d1 = 32'd6; d2 = 32'd7; start = 1'b1;
    exp_q.push_back(32'd42);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, lat, busy_cnt);
    check("b2b_first_latency", lat, 33);
    sel = DIV; d1 = 32'hFFFFFF9C; d2 = 32'd7; start = 1'b1;
    exp_q.push_back(32'hFFFFFFF2);
    last_res = 32'hFFFFFFF2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, lat, busy_cnt);
    check("b2b_second_latency", lat, 33);
    check("b2b_second_busy", busy_cnt, 33);

    // flush mid-multiply
    @(negedge clk);
    sel = MUL; d1 = 32'd3; d2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_flush", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("busy_after_flush", busy, 1'b0);
    check("data_out_after_flush", dout, last_res);
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    check("no_done_after_flush", lat, 0);

    // flush in IDLE cancels a same-edge start
    @(negedge clk);
    sel = MUL; d1 = 32'd3; d2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_cancels_start", busy, 1'b0);

    // unit still works after the abort
    run_op(MUL,    32'd3,        32'd5,        32'd15,       33, 1'b0);

    // reset mid-multiply
    @(negedge clk);
    sel = MUL; d1 = 32'd9; d2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_data_out", dout, 32'd0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_zero", zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    check("queue_drained_w8", exp8_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
